checker_hm_fetch: RTL and testbench

- Fetches one 4 KiB host-memory page for the checker. Sits directly downstream of checker_read's hm_* port.
- Accepts a page address and start from checker_read, then splits the page into fixed-size read requests on the memory read bus.
- Writes the returned qwords into the page buffer and reports completion to checker_read as a single-cycle end, error or timeout pulse.

---
 rtl/checker_hm_fetch.sv | 185 ++++++++++++++++++
 tb/tb_checker_hm_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checker_hm_fetch.sv
// checker_hm_fetch: fetches one 4 KiB host-memory page as CHUNK_BYTES reads and writes the qwords into the page buffer.
// Define CHECKER_HM_FETCH_STATS_EN to add the saturating stat_pages/stat_errors/stat_timeouts counters.
//
// state | meaning
// IDLE  | waiting for hm_start
// RUN   | issuing reads, writing returned qwords
// DRAIN | issue stopped, discarding beats until all reads return
// HOLD  | status reported, waiting for hm_start to drop
module checker_hm_fetch #(
    parameter int CHUNK_BYTES     = 128,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [63:0] hm_page_addr,
    input  logic        hm_start,
    output logic        hm_end,
    output logic        hm_error,
    output logic        hm_timeout,
    output logic        rd_req_valid,
    input  logic        rd_req_ready,
    output logic [63:0] rd_req_addr,
    output logic [12:0] rd_req_len,
    input  logic        rd_cpl_valid,
    input  logic [63:0] rd_cpl_data,
    input  logic        rd_cpl_error,
    output logic        buf_we,
    output logic [8:0]  buf_addr,
    output logic [63:0] buf_data
`ifdef CHECKER_HM_FETCH_STATS_EN
    ,
    output logic [31:0] stat_pages,
    output logic [15:0] stat_errors,
    output logic [15:0] stat_timeouts
`endif
);

    localparam int NCHUNK = 4096 / CHUNK_BYTES;
    localparam int BEATS  = CHUNK_BYTES / 8;
    localparam int CSH    = $clog2(CHUNK_BYTES);
    localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [9:0] BMASK = 10'(BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HOLD} state_t;

    state_t         state;
    logic [51:0]    base_pg;
    logic [9:0]     req_idx;
    logic [9:0]     beat_idx;
    logic [3:0]     outstanding;
    logic [TW-1:0]  tmo_cnt;
    logic           err_q;
    logic           done_q;

    logic           req_avail;
    logic [11:0]    req_off;
    logic           req_hs;
    logic           in_flow;
    logic           cpl_act;
    logic           chunk_final;
    logic           cpl_last;
    logic           out_dec;
    logic [3:0]     out_next;
    logic           tmo_hit;
    logic           beat_last;
    logic           unused_page_bits;

    assign unused_page_bits = ^hm_page_addr[11:0];

    assign req_avail    = (state == S_RUN) && (req_idx < 10'(NCHUNK))
                          && (outstanding < 4'(MAX_OUTSTANDING));
    assign req_off      = 12'(req_idx) << CSH;
    assign rd_req_valid = req_avail;
    assign rd_req_addr  = req_avail ? {base_pg, req_off} : 64'd0;
    assign rd_req_len   = req_avail ? 13'(CHUNK_BYTES) : 13'd0;
    assign req_hs       = req_avail & rd_req_ready;

    assign in_flow     = (state == S_RUN) || (state == S_DRAIN);
    assign cpl_act     = in_flow & rd_cpl_valid;
    assign chunk_final = (beat_idx & BMASK) == BMASK;
    // an error beat terminates its chunk, so it retires one outstanding read
    assign cpl_last    = cpl_act & (rd_cpl_error | chunk_final);
    assign out_dec     = cpl_last & ((outstanding != 4'd0) | req_hs);
    assign out_next    = outstanding + {3'd0, req_hs} - {3'd0, out_dec};
    assign tmo_hit     = in_flow & ~rd_cpl_valid & (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign beat_last   = (beat_idx == 10'd511);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            base_pg     <= '0;
            req_idx     <= '0;
            beat_idx    <= '0;
            outstanding <= '0;
            tmo_cnt     <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            hm_end      <= 1'b0;
            hm_error    <= 1'b0;
            hm_timeout  <= 1'b0;
            buf_we      <= 1'b0;
            buf_addr    <= '0;
            buf_data    <= '0;
        end else begin
            buf_we     <= 1'b0;
            hm_error   <= 1'b0;
            hm_timeout <= 1'b0;
            hm_end     <= done_q;
            done_q     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hm_start) begin
                        base_pg     <= hm_page_addr[63:12];
                        req_idx     <= '0;
                        beat_idx    <= '0;
                        outstanding <= '0;
                        tmo_cnt     <= '0;
                        err_q       <= 1'b0;
                        state       <= S_RUN;
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (req_hs)
                        req_idx <= req_idx + 10'd1;
                    outstanding <= out_next;
                    tmo_cnt     <= rd_cpl_valid ? '0 : tmo_cnt + TW'(1);
                    // after an error beat, realign to the first beat of the next chunk
                    if (cpl_act)
                        beat_idx <= rd_cpl_error ? (beat_idx | BMASK) + 10'd1 : beat_idx + 10'd1;
                    if (tmo_hit) begin
                        hm_timeout  <= 1'b1;
                        outstanding <= '0;
                        state       <= S_HOLD;
                    end else if (state == S_RUN) begin
                        if (cpl_act && rd_cpl_error) begin
                            err_q <= 1'b1;
                            state <= S_DRAIN;
                        end else begin
                            if (cpl_act) begin
                                buf_we   <= 1'b1;
                                buf_addr <= beat_idx[8:0];
                                buf_data <= rd_cpl_data;
                            end
                            if (cpl_act && beat_last) begin
                                done_q      <= 1'b1;
                                outstanding <= '0;
                                state       <= S_HOLD;
                            end else if (!hm_start) begin
                                err_q <= 1'b0;
                                state <= S_DRAIN;
                            end
                        end
                    end else if (outstanding == 4'd0) begin
                        hm_error <= err_q;
                        state    <= err_q ? S_HOLD : S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (!hm_start)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CHECKER_HM_FETCH_STATS_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            stat_pages    <= '0;
            stat_errors   <= '0;
            stat_timeouts <= '0;
        end else begin
            if (hm_end && stat_pages != '1)
                stat_pages <= stat_pages + 32'd1;
            if (hm_error && stat_errors != '1)
                stat_errors <= stat_errors + 16'd1;
            if (hm_timeout && stat_timeouts != '1)
                stat_timeouts <= stat_timeouts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_checker_hm_fetch.sv
// Bench for checker_hm_fetch: a memory model answers read requests, a scoreboard queue holds the
// expected page-buffer writes and a monitor pops and compares them as the DUT writes.
module tb_checker_hm_fetch;

    localparam int CHUNK = 128;
    localparam int MAXO  = 4;
    localparam int TMO   = 64;
    localparam int BEATS = CHUNK / 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [63:0] hm_page_addr;
    logic        hm_start;
    logic        hm_end, hm_error, hm_timeout;
    logic        rd_req_valid, rd_req_ready;
    logic [63:0] rd_req_addr;
    logic [12:0] rd_req_len;
    logic        rd_cpl_valid, rd_cpl_error;
    logic [63:0] rd_cpl_data;
    logic        buf_we;
    logic [8:0]  buf_addr;
    logic [63:0] buf_data;
`ifdef CHECKER_HM_FETCH_STATS_EN
    logic [31:0] stat_pages;
    logic [15:0] stat_errors, stat_timeouts;
`endif

    always #5 sys_clk = ~sys_clk;

    checker_hm_fetch #(.CHUNK_BYTES(CHUNK), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .hm_page_addr(hm_page_addr), .hm_start(hm_start),
        .hm_end(hm_end), .hm_error(hm_error), .hm_timeout(hm_timeout),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_cpl_valid(rd_cpl_valid), .rd_cpl_data(rd_cpl_data), .rd_cpl_error(rd_cpl_error),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data)
`ifdef CHECKER_HM_FETCH_STATS_EN
        , .stat_pages(stat_pages), .stat_errors(stat_errors), .stat_timeouts(stat_timeouts)
`endif
    );

    typedef struct {
        logic [8:0]  a;
        logic [63:0] d;
    } wr_t;
    wr_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // memory-model knobs and state
    int          stall_len, req_limit, err_at, stop_after;
    bit          cpl_en, drain_mode, stale_mode, was_stalled;
    int          reqs_acc, exp_req_n, cur_chunk, beat_i, gap, beats_sent;
    int          inflight, max_inflight, stall_ctr, last_beat_cyc;
    logic [63:0] base_exp, stall_addr;
    logic [15:0] tag;

    // monitor counters
    int n_wr = 0, n_end = 0, n_err = 0, n_to = 0;
    int end_cyc = 0, err_cyc = 0, to_cyc = 0, last_wr_cyc = 0, wr511_cyc = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int g, input logic [15:0] t);
        return {t, 16'hC0DE, 32'(g) * 32'h9E37_79B1};
    endfunction

    task automatic clr();
        stall_len = 0; req_limit = 1000; err_at = -1; stop_after = -1;
        cpl_en = 1; drain_mode = 0; stale_mode = 0; was_stalled = 0;
        reqs_acc = 0; exp_req_n = 0; cur_chunk = 0; beat_i = 0; gap = 2; beats_sent = 0;
        inflight = 0; max_inflight = 0; stall_ctr = 0; last_beat_cyc = 0;
    endtask

    task automatic start_fetch(input logic [63:0] page, input logic [15:0] t);
        @(negedge sys_clk);
        base_exp     = {page[63:12], 12'h000};
        tag          = t;
        hm_page_addr = page;
        hm_start     = 1'b1;
    endtask

    task automatic chk_rst(input string nm);
        check({nm, "_ctrl"}, 64'({hm_end, hm_error, hm_timeout, rd_req_valid, buf_we, rd_req_len, buf_addr}), 64'd0);
        check({nm, "_req_addr"}, rd_req_addr, 64'd0);
        check({nm, "_buf_data"}, buf_data, 64'd0);
    endtask

    // full good fetch; hm_start stays high through HOLD before being released
    task automatic do_fetch(input logic [63:0] page, input logic [15:0] t, input int stall, input string nm);
        int e0, w0, r0, o0;
        clr();
        stall_len = stall;
        e0 = n_end; w0 = n_wr; r0 = n_err; o0 = n_to;
        start_fetch(page, t);
        for (int i = 0; i < 5000 && n_end == e0; i++) @(negedge sys_clk);
        repeat (20) begin
            @(negedge sys_clk);
            check({nm, "_hold_req_valid"}, 64'(rd_req_valid), 64'd0);
        end
        check({nm, "_end_count"}, 64'(n_end - e0), 64'd1);
        check({nm, "_writes"}, 64'(n_wr - w0), 64'd512);
        check({nm, "_requests"}, 64'(exp_req_n), 64'd32);
        check({nm, "_exp_left"}, 64'(exp_q.size()), 64'd0);
        check({nm, "_err_to"}, 64'((n_err - r0) + (n_to - o0)), 64'd0);
        check({nm, "_max_inflight"}, 64'(max_inflight), 64'(MAXO));
        check({nm, "_end_after_last_wr"}, 64'((end_cyc - wr511_cyc) >= 1 && (end_cyc - wr511_cyc) <= 2), 64'd1);
        hm_start = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    // memory model: drives completions and request ready for the next rising edge
    initial begin : stim
        int g;
        forever begin
            @(negedge sys_clk);
            rd_cpl_valid = 1'b0;
            rd_cpl_error = 1'b0;
            rd_cpl_data  = 64'd0;
            if (sys_rst) begin
                rd_req_ready = 1'b0;
            end else begin
                if (stale_mode) begin
                    rd_cpl_valid = 1'b1;
                    rd_cpl_data  = 64'h5A5A_5A5A_DEAD_0001;
                end else if (cpl_en && cur_chunk < reqs_acc && (stop_after < 0 || beats_sent <= stop_after)) begin
                    if (gap > 0) begin
                        gap--;
                    end else begin
                        g = cur_chunk * BEATS + beat_i;
                        rd_cpl_valid  = 1'b1;
                        rd_cpl_data   = pat(g, tag);
                        last_beat_cyc = cyc;
                        beats_sent++;
                        if (g == err_at) begin
                            rd_cpl_error = 1'b1;
                            drain_mode   = 1;
                            beat_i       = BEATS - 1;
                        end else if (!drain_mode) begin
                            exp_q.push_back('{a: 9'(g), d: pat(g, tag)});
                        end
                        if (beat_i == BEATS - 1) begin
                            beat_i = 0;
                            cur_chunk++;
                            inflight--;
                            gap = 4;
                        end else begin
                            beat_i++;
                        end
                    end
                end
                if (was_stalled) begin
                    check("req_stall_valid", 64'(rd_req_valid), 64'd1);
                    check("req_stall_addr", rd_req_addr, stall_addr);
                end
                if (rd_req_valid && stall_ctr < stall_len) begin
                    rd_req_ready = 1'b0;
                    stall_ctr++;
                    was_stalled = 1;
                    stall_addr  = rd_req_addr;
                end else begin
                    rd_req_ready = (reqs_acc < req_limit);
                    was_stalled  = 0;
                end
                if (rd_req_valid && rd_req_ready) begin
                    check("req_addr", rd_req_addr, base_exp + 64'(exp_req_n * CHUNK));
                    check("req_len", 64'(rd_req_len), 64'(CHUNK));
                    exp_req_n++;
                    reqs_acc++;
                    inflight++;
                    if (inflight > max_inflight) max_inflight = inflight;
                    stall_ctr = 0;
                end
            end
        end
    end

    // scoreboard monitor
    initial begin : mon
        wr_t e;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst) begin
                if (buf_we) begin
                    n_wr++;
                    last_wr_cyc = cyc;
                    if (buf_addr == 9'd511) wr511_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: got buf_we=1 addr=%0d data=0x%0h, expected no write", buf_addr, buf_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("buf_addr", 64'(buf_addr), 64'(e.a));
                        check("buf_data", buf_data, e.d);
                    end
                end
                if (hm_end)     begin n_end++; end_cyc = cyc; end
                if (hm_error)   begin n_err++; err_cyc = cyc; end
                if (hm_timeout) begin n_to++;  to_cyc  = cyc; end
                check("pulse_onehot", 64'({hm_end, hm_error, hm_timeout} inside {3'b000, 3'b001, 3'b010, 3'b100}), 64'd1);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected test done");
        $fatal(1);
    end

    initial begin : main
        int e0, w0, r0, o0, q0;
        sys_rst = 1'b1; hm_start = 1'b0; hm_page_addr = 64'd0; rd_req_ready = 1'b0;
        rd_cpl_valid = 1'b0; rd_cpl_error = 1'b0; rd_cpl_data = 64'd0;
        tag = 16'd0; base_exp = 64'd0; stall_addr = 64'd0;
        clr();
        repeat (2) @(negedge sys_clk);
        chk_rst("reset");
        sys_rst = 1'b0;

        do_fetch(64'h0000_0000_0000_1234, 16'h0001, 0, "normal");
        do_fetch(64'h0000_0042_0000_5FFF, 16'h0002, 5, "backpressure");

        // completion error on beat 100
        clr();
        err_at = 100;
        e0 = n_end; w0 = n_wr; r0 = n_err; o0 = n_to;
        start_fetch(64'h3000, 16'h0003);
        for (int i = 0; i < 3000 && n_err == r0; i++) @(negedge sys_clk);
        repeat (10) @(negedge sys_clk);
        check("err_pulse_count", 64'(n_err - r0), 64'd1);
        check("err_writes", 64'(n_wr - w0), 64'd100);
        check("err_no_end_to", 64'((n_end - e0) + (n_to - o0)), 64'd0);
        check("err_drained", 64'(cur_chunk), 64'(reqs_acc));
        check("err_after_drain", 64'(err_cyc > last_beat_cyc), 64'd1);
        check("err_exp_left", 64'(exp_q.size()), 64'd0);
        hm_start = 1'b0;
        repeat (3) @(negedge sys_clk);

        // completions stop after beat 40
        clr();
        stop_after = 40;
        e0 = n_end; w0 = n_wr; r0 = n_err; o0 = n_to;
        start_fetch(64'h4000, 16'h0004);
        for (int i = 0; i < 3000 && n_to == o0; i++) @(negedge sys_clk);
        check("to_pulse_count", 64'(n_to - o0), 64'd1);
        check("to_writes", 64'(n_wr - w0), 64'd41);
        check("to_latency", 64'(to_cyc - last_wr_cyc), 64'(TMO));
        stale_mode = 1;
        repeat (5) @(negedge sys_clk);
        hm_start = 1'b0;
        repeat (5) @(negedge sys_clk);
        stale_mode = 0;
        repeat (2) @(negedge sys_clk);
        check("to_stale_writes", 64'(n_wr - w0), 64'd41);
        check("to_no_end_err", 64'((n_end - e0) + (n_err - r0)), 64'd0);
        check("to_exp_left", 64'(exp_q.size()), 64'd0);

        // abort after two requests, then a fresh fetch
        clr();
        cpl_en = 0;
        req_limit = 2;
        e0 = n_end; w0 = n_wr; r0 = n_err; o0 = n_to;
        start_fetch(64'h5000, 16'h0005);
        for (int i = 0; i < 100 && reqs_acc < 2; i++) @(negedge sys_clk);
        @(negedge sys_clk);
        hm_start = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("abort_req_valid", 64'(rd_req_valid), 64'd0);
        drain_mode = 1;
        cpl_en = 1;
        for (int i = 0; i < 200 && cur_chunk < 2; i++) @(negedge sys_clk);
        repeat (5) @(negedge sys_clk);
        check("abort_requests", 64'(exp_req_n), 64'd2);
        check("abort_writes", 64'(n_wr - w0), 64'd0);
        check("abort_no_pulse", 64'((n_end - e0) + (n_err - r0) + (n_to - o0)), 64'd0);
        do_fetch(64'h2000, 16'h0006, 0, "after_abort");

        // asynchronous reset in the middle of a fetch
        clr();
        w0 = n_wr;
        start_fetch(64'h6000, 16'h0007);
        for (int i = 0; i < 2000 && (n_wr - w0) < 20; i++) @(negedge sys_clk);
        @(posedge sys_clk);
        #2 sys_rst = 1'b1;
        #1 chk_rst("midrun_reset");
        hm_start = 1'b0;
        exp_q.delete();
        clr();
        repeat (3) @(negedge sys_clk);
`ifdef CHECKER_HM_FETCH_STATS_EN
        check("stat_reset", 64'({stat_pages, stat_errors, stat_timeouts}), 64'd0);
`endif
        sys_rst = 1'b0;
        w0 = n_wr;
        repeat (5) begin
            @(negedge sys_clk);
            check("post_reset_idle", 64'(rd_req_valid), 64'd0);
        end
        check("post_reset_writes", 64'(n_wr - w0), 64'd0);
        q0 = 16'h0010;
        for (int k = 0; k < 3; k++)
            do_fetch(64'h7000 + 64'(k) * 64'h1000, 16'(q0 + k), 0, "post_reset");
`ifdef CHECKER_HM_FETCH_STATS_EN
        check("stat_pages", 64'(stat_pages), 64'd3);
        check("stat_err_to", 64'({stat_errors, stat_timeouts}), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
